// File: rtl/dmem_copy_engine.sv
// Word-at-a-time data-memory copy/fill engine: one word per clock, ascending
// addresses wrapping at MEM_DEPTH, with a running word count and wrapping checksum.
module dmem_copy_engine #(
  parameter int MEM_DEPTH = 1024,
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     src_addr,
  input  logic [WIDTH-1:0]     dst_addr,
  input  logic [ADDR_BITS:0]   length,
  input  logic [WIDTH-1:0]     fill_data,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     mem_read_data,
  output logic [WIDTH-1:0]     mem_read_addr,
  output logic [WIDTH-1:0]     mem_write_addr,
  output logic                 mem_write_en,
  output logic [WIDTH-1:0]     mem_write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [ADDR_BITS:0]   words_done,
  output logic [WIDTH-1:0]     checksum
);

  localparam int LW = ADDR_BITS + 1;

  // Handshake: start is a single-cycle request honoured only in IDLE; there is
  // no back-pressure. done is a one-cycle pulse; abort acts only while busy.
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic                 mode_q;
  logic [ADDR_BITS-1:0] src_q;
  logic [ADDR_BITS-1:0] dst_q;
  logic [LW-1:0]        len_q;
  logic [WIDTH-1:0]     fill_q;
  logic [LW-1:0]        len_clamped;
  logic [ADDR_BITS-1:0] rd_off;
  logic [ADDR_BITS-1:0] wr_off;
  logic [WIDTH-1:0]     wdata;
  logic                 unused_addr_bits;

  // Only the word-address LSBs matter; the memory is a power-of-two ring.
  assign unused_addr_bits = ^{src_addr[WIDTH-1:ADDR_BITS], dst_addr[WIDTH-1:ADDR_BITS]};

  assign len_clamped = (length > LW'(MEM_DEPTH)) ? LW'(MEM_DEPTH) : length;
  assign rd_off      = src_q + words_done[ADDR_BITS-1:0];
  assign wr_off      = dst_q + words_done[ADDR_BITS-1:0];
  assign wdata       = mode_q ? fill_q : mem_read_data;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (len_clamped == '0) ? DONE : XFER;
      end
      XFER: begin
        if (abort)                             state_nx = IDLE;
        else if (words_done + LW'(1) == len_q) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by XFER so reset alone forces them to zero.
  always_comb begin
    busy           = (state == XFER);
    done           = (state == DONE);
    mem_write_en   = (state == XFER) && !abort;
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_write_data = '0;
    if (state == XFER) begin
      mem_read_addr  = {{(WIDTH-ADDR_BITS){1'b0}}, rd_off};
      mem_write_addr = {{(WIDTH-ADDR_BITS){1'b0}}, wr_off};
      mem_write_data = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      aborted    <= 1'b0;
      words_done <= '0;
      checksum   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mode_q     <= mode;
        src_q      <= src_addr[ADDR_BITS-1:0];
        dst_q      <= dst_addr[ADDR_BITS-1:0];
        len_q      <= len_clamped;
        fill_q     <= fill_data;
        aborted    <= 1'b0;
        words_done <= '0;
        checksum   <= '0;
      end else if (state == XFER) begin
        if (abort) begin
          aborted <= 1'b1;
        end else begin
          words_done <= words_done + LW'(1);
          checksum   <= checksum + wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: behavioural memory plus a reference model that
// applies each operation as a plain ascending loop over an array.
module tb_dmem_copy_engine;

  localparam int DEPTH = 1024;
  localparam int W     = 32;
  localparam int AB    = 10;
  localparam int LW    = AB + 1;

  logic          clk;
  logic          reset_b;
  logic          start;
  logic          mode;
  logic [W-1:0]  src_addr;
  logic [W-1:0]  dst_addr;
  logic [LW-1:0] length;
  logic [W-1:0]  fill_data;
  logic          abort;
  logic [W-1:0]  mem_read_data;
  logic [W-1:0]  mem_read_addr;
  logic [W-1:0]  mem_write_addr;
  logic          mem_write_en;
  logic [W-1:0]  mem_write_data;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] words_done;
  logic [W-1:0]  checksum;

  dmem_copy_engine #(.MEM_DEPTH(DEPTH), .WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .abort(abort), .mem_read_data(mem_read_data),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .busy(busy), .done(done), .aborted(aborted),
    .words_done(words_done), .checksum(checksum)
  );

  logic [W-1:0]      mem     [DEPTH];
  logic [W-1:0]      ref_mem [DEPTH];
  logic [AB+W-1:0]   exp_q[$];
  logic [AB+W-1:0]   got_q[$];
  int checks = 0;
  int passes = 0;
  int write_count = 0;
  int done_count = 0;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_read_data = mem[mem_read_addr[AB-1:0]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_write_addr[AB-1:0]] <= mem_write_data;
      got_q.push_back({mem_write_addr[AB-1:0], mem_write_data});
      write_count = write_count + 1;
    end
    if (done) done_count = done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the operation is an ascending loop of n word moves on an array.
  task automatic model_op(input logic m, input logic [W-1:0] s, input logic [W-1:0] d,
                          input int len, input logic [W-1:0] f, input int limit,
                          output logic [LW-1:0] wd, output logic [W-1:0] cs);
    int n;
    int a;
    logic [W-1:0] v;
    n = (len > DEPTH) ? DEPTH : len;
    if (limit >= 0 && limit < n) n = limit;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      a = int'((d + W'(i)) % DEPTH);
      v = m ? f : ref_mem[int'((s + W'(i)) % DEPTH)];
      ref_mem[a] = v;
      exp_q.push_back({a[AB-1:0], v});
      cs = cs + v;
    end
    wd = LW'(n);
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic int stream_diff();
    int n = 0;
    if (got_q.size() != exp_q.size()) return 1 + got_q.size() + exp_q.size();
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // Driver: issues one operation and runs it to the done pulse, then one more
  // cycle into IDLE. lat counts cycles from the start cycle to the done cycle.
  task automatic run_op(input logic m, input logic [W-1:0] s, input logic [W-1:0] d,
                        input int len, input logic [W-1:0] f, input bit poke,
                        output int lat, output int bad_xfer, output int writes);
    int wc0;
    got_q.delete();
    exp_q.delete();
    wc0 = write_count;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d;
    length = LW'(len); fill_data = f;
    tick();
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; fill_data = $urandom;
    lat = 1;
    bad_xfer = 0;
    while (done !== 1'b1 && lat < 2100) begin
      if (busy !== 1'b1 || mem_write_en !== 1'b1) bad_xfer++;
      if (poke && lat == 2) begin
        start = 1'b1; mode = ~m; length = 5; src_addr = 0; dst_addr = 500;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    tick();
    writes = write_count - wc0;
  endtask

  task automatic test_reset();
    reset_b = 1'b1;
    #2 reset_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, mem_write_en, words_done, checksum,
         mem_read_addr, mem_write_addr, mem_write_data} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b ab=%b we=%b wd=%0d cs=%h ra=%h wa=%h wdat=%h want all 0",
               busy, done, aborted, mem_write_en, words_done, checksum,
               mem_read_addr, mem_write_addr, mem_write_data);
    else passes++;
    repeat (2) @(posedge clk);
    #3 reset_b = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_copy();
    int lat, bad, wr;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    for (int i = 0; i < 4; i++) begin
      mem[i] = W'(i + 1);
      ref_mem[i] = W'(i + 1);
    end
    run_op(1'b0, 0, 100, 4, 0, 1'b0, lat, bad, wr);
    model_op(1'b0, 0, 100, 4, 0, -1, ewd, ecs);
    checks++; if (lat !== 5) $display("FAIL copy_latency got %0d want 5", lat); else passes++;
    checks++; if (checksum !== 32'd10) $display("FAIL copy_checksum got %0d want 10", checksum); else passes++;
    checks++; if (words_done !== 11'd4) $display("FAIL copy_words got %0d want 4", words_done); else passes++;
    checks++; if (wr !== 4 || bad !== 0) $display("FAIL copy_writes got %0d (bad %0d) want 4 (0)", wr, bad); else passes++;
    checks++;
    if ({mem[100], mem[101], mem[102], mem[103]} !== {32'd1, 32'd2, 32'd3, 32'd4})
      $display("FAIL copy_data got %0d %0d %0d %0d want 1 2 3 4", mem[100], mem[101], mem[102], mem[103]);
    else passes++;
    checks++; if (stream_diff() !== 0) $display("FAIL copy_stream got %0d diffs want 0", stream_diff()); else passes++;
  endtask

  task automatic test_fill_wrap();
    int lat, bad, wr;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    run_op(1'b1, $urandom, 1022, 4, 32'hDEADBEEF, 1'b0, lat, bad, wr);
    model_op(1'b1, 0, 1022, 4, 32'hDEADBEEF, -1, ewd, ecs);
    checks++; if (checksum !== 32'h7AB6FBBC) $display("FAIL fill_checksum got %h want 7ab6fbbc", checksum); else passes++;
    checks++;
    if ({mem[1022], mem[1023], mem[0], mem[1]} !== {4{32'hDEADBEEF}})
      $display("FAIL fill_wrap_data got %h %h %h %h want deadbeef x4", mem[1022], mem[1023], mem[0], mem[1]);
    else passes++;
    checks++; if (lat !== 5 || wr !== 4) $display("FAIL fill_latency got lat %0d writes %0d want 5 4", lat, wr); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL fill_mem got %0d diffs want 0", mem_diff()); else passes++;
  endtask

  task automatic test_abort();
    int wc0, dc0;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    logic [W-1:0] s, d;
    s = W'($urandom_range(0, 400));
    d = W'($urandom_range(500, 900));
    got_q.delete();
    exp_q.delete();
    wc0 = write_count;
    dc0 = done_count;
    start = 1'b1; mode = 1'b0; src_addr = s; dst_addr = d; length = 8;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    #1;
    checks++; if (mem_write_en !== 1'b0) $display("FAIL abort_write_gate got %b want 0", mem_write_en); else passes++;
    tick();
    abort = 1'b0;
    model_op(1'b0, s, d, 8, 0, 2, ewd, ecs);
    checks++; if (busy !== 1'b0 || aborted !== 1'b1) $display("FAIL abort_state got busy %b aborted %b want 0 1", busy, aborted); else passes++;
    checks++; if (words_done !== 11'd2) $display("FAIL abort_words got %0d want 2", words_done); else passes++;
    checks++; if (write_count - wc0 !== 2) $display("FAIL abort_writes got %0d want 2", write_count - wc0); else passes++;
    // abort seen in IDLE must not disturb anything
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    checks++; if (done_count - dc0 !== 0) $display("FAIL abort_no_done got %0d pulses want 0", done_count - dc0); else passes++;
    checks++;
    if (aborted !== 1'b1 || checksum !== ecs || words_done !== ewd)
      $display("FAIL abort_hold got ab %b cs %h wd %0d want 1 %h %0d", aborted, checksum, words_done, ecs, ewd);
    else passes++;
    checks++; if (mem_diff() !== 0 || stream_diff() !== 0) $display("FAIL abort_mem got %0d diffs want 0", mem_diff() + stream_diff()); else passes++;
  endtask

  task automatic test_zero_length();
    int lat, bad, wr;
    run_op(1'b0, $urandom, $urandom, 0, 0, 1'b0, lat, bad, wr);
    checks++; if (lat !== 1) $display("FAIL zero_latency got %0d want 1", lat); else passes++;
    checks++; if (wr !== 0) $display("FAIL zero_writes got %0d want 0", wr); else passes++;
    checks++;
    if (checksum !== '0 || words_done !== '0 || aborted !== 1'b0)
      $display("FAIL zero_state got cs %h wd %0d ab %b want 0 0 0", checksum, words_done, aborted);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int wc0;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    logic [W-1:0] s, d;
    s = W'($urandom_range(0, 400));
    d = W'($urandom_range(500, 900));
    got_q.delete();
    exp_q.delete();
    wc0 = write_count;
    start = 1'b1; mode = 1'b0; src_addr = s; dst_addr = d; length = 8;
    tick();
    start = 1'b0;
    tick();
    reset_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, mem_write_en, words_done, checksum,
         mem_read_addr, mem_write_addr, mem_write_data} !== '0)
      $display("FAIL midreset_outputs got busy=%b we=%b wd=%0d cs=%h wa=%h want all 0",
               busy, mem_write_en, words_done, checksum, mem_write_addr);
    else passes++;
    repeat (3) tick();
    #2 reset_b = 1'b1;
    tick();
    model_op(1'b0, s, d, 8, 0, 1, ewd, ecs);
    checks++; if (write_count - wc0 !== 1) $display("FAIL midreset_writes got %0d want 1", write_count - wc0); else passes++;
    checks++; if (busy !== 1'b0 || mem_write_en !== 1'b0) $display("FAIL midreset_idle got busy %b we %b want 0 0", busy, mem_write_en); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL midreset_mem got %0d diffs want 0", mem_diff()); else passes++;
  endtask

  task automatic test_overlap_ignored_start();
    int lat, bad, wr;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    mem[10] = 32'd7;
    ref_mem[10] = 32'd7;
    run_op(1'b0, 10, 11, 3, 0, 1'b1, lat, bad, wr);
    model_op(1'b0, 10, 11, 3, 0, -1, ewd, ecs);
    checks++;
    if ({mem[11], mem[12], mem[13]} !== {3{32'd7}})
      $display("FAIL overlap_data got %0d %0d %0d want 7 7 7", mem[11], mem[12], mem[13]);
    else passes++;
    checks++; if (lat !== 4 || wr !== 3 || bad !== 0) $display("FAIL overlap_timing got lat %0d wr %0d bad %0d want 4 3 0", lat, wr, bad); else passes++;
    checks++; if (checksum !== 32'd21 || words_done !== 11'd3) $display("FAIL overlap_totals got cs %0d wd %0d want 21 3", checksum, words_done); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL overlap_mem got %0d diffs want 0", mem_diff()); else passes++;
  endtask

  task automatic test_random();
    int lat, bad, wr, len;
    logic m;
    logic [W-1:0] s, d, f;
    logic [LW-1:0] ewd;
    logic [W-1:0] ecs;
    for (int it = 0; it < 8; it++) begin
      m = 1'($urandom_range(0, 1));
      s = $urandom; d = $urandom; f = $urandom;
      len = (it == 6) ? DEPTH : (it == 7) ? $urandom_range(DEPTH + 1, 2047) : $urandom_range(1, 40);
      run_op(m, s, d, len, f, 1'b0, lat, bad, wr);
      model_op(m, s, d, len, f, -1, ewd, ecs);
      checks++; if (lat !== int'(ewd) + 1 || wr !== int'(ewd) || bad !== 0)
        $display("FAIL rand%0d_timing got lat %0d wr %0d bad %0d want %0d %0d 0", it, lat, wr, bad, ewd + 1, ewd);
      else passes++;
      checks++; if (words_done !== ewd || checksum !== ecs)
        $display("FAIL rand%0d_totals got wd %0d cs %h want %0d %h", it, words_done, checksum, ewd, ecs);
      else passes++;
      checks++; if (stream_diff() !== 0 || mem_diff() !== 0)
        $display("FAIL rand%0d_mem got %0d diffs want 0", it, stream_diff() + mem_diff());
      else passes++;
    end
    repeat (4) tick();
    checks++; if (words_done !== ewd || checksum !== ecs)
      $display("FAIL idle_hold got wd %0d cs %h want %0d %h", words_done, checksum, ewd, ecs);
    else passes++;
  endtask

  initial begin
    start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_data = '0; abort = 1'b0; reset_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_copy();
    test_fill_wrap();
    test_abort();
    test_zero_length();
    test_reset_mid();
    test_overlap_ignored_start();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
DMEM_COPY_ENGINE -- requirements
Module: dmem_copy_engine

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of data-memory words.
REQ-002 SHALL have parameter WIDTH, default 32, data and address bus width.
REQ-003 SHALL have parameter ADDR_BITS, default 10, effective word-address bits (log2 MEM_DEPTH).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset_b  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  0 = copy, 1 = fill; sampled with start.
REQ-008 SHALL have port src_addr  input  WIDTH  copy source start word address; sampled with start.
REQ-009 SHALL have port dst_addr  input  WIDTH  destination start word address; sampled with start.
REQ-010 SHALL have port length  input  ADDR_BITS+1  word count, 0..MEM_DEPTH; sampled with start.
REQ-011 SHALL have port fill_data  input  WIDTH  fill pattern; sampled with start.
REQ-012 SHALL have port abort  input  1  terminate the current operation.
REQ-013 SHALL have port mem_read_data  input  WIDTH  asynchronous read data returned by data memory.
REQ-014 SHALL have port mem_read_addr  output  WIDTH  data-memory read address.
REQ-015 SHALL have port mem_write_addr  output  WIDTH  data-memory write address.
REQ-016 SHALL have port mem_write_en  output  1  data-memory write strobe; memory captures on the next rising clk.
REQ-017 SHALL have port mem_write_data  output  WIDTH  data-memory write data.
REQ-018 SHALL have port busy  output  1  high while in XFER.
REQ-019 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-020 SHALL have port aborted  output  1  sticky; set when an abort terminates XFER; cleared by the next accepted start.
REQ-021 SHALL have port words_done  output  ADDR_BITS+1  count of words written by the current or last operation.
REQ-022 SHALL have port checksum  output  WIDTH  wrapping sum of all words written by the current or last operation.

Function
REQ-023 SHALL implement states IDLE, XFER and DONE.
REQ-024 IDLE with start=1 SHALL latch the operands, clear words_done, checksum and aborted, and go to XFER, or to DONE if length=0.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 XFER SHALL process one word per cycle; word i uses read address src+i and write address dst+i, each taken modulo MEM_DEPTH (ADDR_BITS LSBs, upper bits zero).
REQ-027 In copy mode, XFER SHALL drive mem_read_addr with the current source address and mem_write_data with mem_read_data in the same cycle (combinational path).
REQ-028 In fill mode, XFER SHALL drive mem_write_data with the latched fill_data; mem_read_addr is don't-care.
REQ-029 In XFER, mem_write_en SHALL be 1 every cycle; outside XFER it SHALL be 0.
REQ-030 At each XFER clock edge, words_done SHALL increment by 1 and checksum SHALL add mem_write_data modulo 2^WIDTH.
REQ-031 After the edge that writes word length-1, the block SHALL go to DONE; latency from start to done is length+1 cycles.
REQ-032 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-033 abort=1 in XFER SHALL deassert mem_write_en in that same cycle, so no write occurs on that edge, then set aborted and go to IDLE without a done pulse.
REQ-034 abort in IDLE or DONE SHALL be ignored.
REQ-035 Copy order SHALL always be ascending; overlapping regions with dst>src SHALL give the ascending-order result, with already-overwritten words recopied.
REQ-036 Address wrap from MEM_DEPTH-1 to 0 SHALL be seamless.
REQ-037 length=MEM_DEPTH SHALL be a legal request; length values greater than MEM_DEPTH SHALL be clamped to MEM_DEPTH.
REQ-038 words_done and checksum SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-039 reset_b=0 SHALL asynchronously force IDLE and set busy, done, aborted, mem_write_en, words_done, checksum and all address/data outputs to 0.
REQ-040 Reset asserted during XFER SHALL stop writes immediately, with no further mem_write_en; the block SHALL resume in IDLE after reset_b rises.

Verification
REQ-041 Copy test: mem[0..3]=1,2,3,4; start copy src=0, dst=100, length=4 -> mem[100..103]=1,2,3,4; done on cycle 5 after start; checksum=10; words_done=4.
REQ-042 Fill with wrap: start fill fill_data=0xDEADBEEF, dst=1022, length=4 -> mem[1022], mem[1023], mem[0] and mem[1] are 0xDEADBEEF; checksum=0x7AB6FBBC.
REQ-043 Zero length: length=0 -> no mem_write_en pulse; done on the cycle after start; checksum=0; words_done=0.
REQ-044 Abort: copy length=8, abort in 3rd XFER cycle -> exactly 2 words written; aborted=1; done never pulses; words_done=2.
REQ-045 Reset mid-XFER: reset_b low during XFER cycle 2 -> all outputs 0 immediately; no writes while reset; busy=0.
REQ-046 Overlap and ignored start: copy src=10, dst=11, length=3 with mem[10]=7 -> mem[11..13]=7; start pulsed while busy is ignored.
